// File: rtl/mul_div_unit_pkg.sv
// Shared types, widths and arithmetic helpers for the iterative multiply/divide unit.
package mul_div_unit_pkg;

    localparam int unsigned XLEN     = 32;
    localparam int unsigned DXLEN    = 2 * XLEN;
    localparam int unsigned MDU_ITER = 32;
    localparam int unsigned CNT_W    = 5;

    typedef enum logic [1:0] {
        MDU_MULTU = 2'b00,
        MDU_MULT  = 2'b01,
        MDU_DIVU  = 2'b10,
        MDU_DIV   = 2'b11
    } mdu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_CALC = 2'b01,
        ST_FIX  = 2'b10
    } mdu_state_e;

    typedef struct packed {
        mdu_op_e         op;
        logic [XLEN-1:0] a;
        logic [XLEN-1:0] b;
    } mdu_req_t;

    function automatic logic [XLEN-1:0] neg_x(input logic [XLEN-1:0] v);
        return ~v + XLEN'(1);
    endfunction

    function automatic logic [XLEN-1:0] abs_x(input logic [XLEN-1:0] v);
        return v[XLEN-1] ? neg_x(v) : v;
    endfunction

    function automatic logic [DXLEN-1:0] neg_dx(input logic [DXLEN-1:0] v);
        return ~v + DXLEN'(1);
    endfunction

endpackage

// File: rtl/mul_div_unit_if.sv
// Issue/writeback bundle between the pipeline controller and the multiply/divide unit.
interface mul_div_unit_if;
    import mul_div_unit_pkg::*;

    logic            start;
    logic [1:0]      op;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic            hi_we;
    logic            lo_we;
    logic [XLEN-1:0] wdata;
    logic [XLEN-1:0] hi;
    logic [XLEN-1:0] lo;
    logic            busy;
    logic            done;

    modport master (
        output start, op, a, b, hi_we, lo_we, wdata,
        input  hi, lo, busy, done
    );

    modport slave (
        input  start, op, a, b, hi_we, lo_we, wdata,
        output hi, lo, busy, done
    );

endinterface

// File: rtl/mul_div_unit.sv
// 34-cycle iterative MULT/MULTU/DIV/DIVU engine with private HI/LO and MTHI/MTLO access.
module mul_div_unit
    import mul_div_unit_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    mul_div_unit_if.slave bus
);

    mdu_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             is_div_q, is_div_d;
    logic             neg_lo_q, neg_lo_d;
    logic             neg_hi_q, neg_hi_d;
    logic [DXLEN-1:0] acc_q, acc_d;
    logic [XLEN-1:0]  opb_q, opb_d;
    logic [XLEN-1:0]  hi_q, hi_d;
    logic [XLEN-1:0]  lo_q, lo_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    mdu_req_t         req;
    logic             req_signed;
    logic             req_div;
    logic             req_dz;
    logic             sign_ab;
    logic [XLEN:0]    sum;
    logic [XLEN+1:0]  diff;
    logic [DXLEN-1:0] prod;

    assign req        = '{op: mdu_op_e'(bus.op), a: bus.a, b: bus.b};
    assign req_signed = (req.op == MDU_MULT) || (req.op == MDU_DIV);
    assign req_div    = (req.op == MDU_DIVU) || (req.op == MDU_DIV);
    assign req_dz     = req_div && (req.b == '0);
    assign sign_ab    = req.a[XLEN-1] ^ req.b[XLEN-1];

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= ST_IDLE;
        else      state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (bus.start) state_d = ST_CALC;
            ST_CALC: if (cnt_q == CNT_W'(MDU_ITER - 1)) state_d = ST_FIX;
            ST_FIX:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Datapath and output next-values; divide-by-zero skips abs/negate so HI ends up as raw a
    always_comb begin
        cnt_d    = cnt_q;
        is_div_d = is_div_q;
        neg_lo_d = neg_lo_q;
        neg_hi_d = neg_hi_q;
        acc_d    = acc_q;
        opb_d    = opb_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        sum      = '0;
        diff     = '0;
        prod     = '0;
        unique case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    cnt_d    = '0;
                    busy_d   = 1'b1;
                    is_div_d = req_div;
                    acc_d    = {XLEN'(0), (req_signed && !req_dz) ? abs_x(req.a) : req.a};
                    opb_d    = req_signed ? abs_x(req.b) : req.b;
                    neg_lo_d = req_signed && !req_dz && sign_ab;
                    neg_hi_d = req_signed && !req_dz && (req_div ? req.a[XLEN-1] : sign_ab);
                end else begin
                    if (bus.hi_we) hi_d = bus.wdata;
                    if (bus.lo_we) lo_d = bus.wdata;
                end
            end
            ST_CALC: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (is_div_q) begin
                    // acc = {partial remainder, dividend shifting into quotient}
                    diff = {1'b0, acc_q[DXLEN-1:XLEN-1]} - {2'b00, opb_q};
                    if (!diff[XLEN+1]) acc_d = {diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
                    else               acc_d = {acc_q[DXLEN-2:0], 1'b0};
                end else begin
                    sum   = {1'b0, acc_q[DXLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opb_q} : '0);
                    acc_d = {sum, acc_q[XLEN-1:1]};
                end
            end
            ST_FIX: begin
                busy_d = 1'b0;
                done_d = 1'b1;
                if (is_div_q) begin
                    lo_d = neg_lo_q ? neg_x(acc_q[XLEN-1:0]) : acc_q[XLEN-1:0];
                    hi_d = neg_hi_q ? neg_x(acc_q[DXLEN-1:XLEN]) : acc_q[DXLEN-1:XLEN];
                end else begin
                    prod = neg_lo_q ? neg_dx(acc_q) : acc_q;
                    hi_d = prod[DXLEN-1:XLEN];
                    lo_d = prod[XLEN-1:0];
                end
            end
            default: ;
        endcase
    end

    // Datapath and output registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q    <= '0;
            is_div_q <= 1'b0;
            neg_lo_q <= 1'b0;
            neg_hi_q <= 1'b0;
            acc_q    <= '0;
            opb_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            is_div_q <= is_div_d;
            neg_lo_q <= neg_lo_d;
            neg_hi_q <= neg_hi_d;
            acc_q    <= acc_d;
            opb_q    <= opb_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed plus randomized checks of mul_div_unit against an arithmetic reference model.
module tb_mul_div_unit;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;

    mul_div_unit_if bus ();

    mul_div_unit dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference result as {hi, lo}, computed with plain integer arithmetic
    function automatic logic [63:0] ref_model(input logic [1:0] op, input logic [31:0] a,
                                              input logic [31:0] b);
        longint sa, sb, q, r;
        logic [63:0] res;
        sa = $signed(a);
        sb = $signed(b);
        res = '0;
        case (op)
            2'b00: res = {32'b0, a} * {32'b0, b};
            2'b01: res = 64'(sa * sb);
            2'b10: res = (b == 32'd0) ? {a, 32'hFFFFFFFF} : {a % b, a / b};
            default: begin
                if (b == 32'd0) res = {a, 32'hFFFFFFFF};
                else begin
                    q = sa / sb;
                    r = sa % sb;
                    res = {r[31:0], q[31:0]};
                end
            end
        endcase
        return res;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // poke_kind: 0 none, 1 hi_we while busy, 2 start while busy, 3 lo_we with start
    task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input int poke_at, input int poke_kind);
        logic [63:0] exp;
        logic [31:0] hi_before;
        logic [31:0] lo_before;
        int cyc;
        bit seen;
        exp = ref_model(op, a, b);
        @(negedge clk);
        hi_before = bus.hi;
        lo_before = bus.lo;
        bus.start = 1'b1;
        bus.op    = op;
        bus.a     = a;
        bus.b     = b;
        if (poke_kind == 3) begin
            bus.lo_we = 1'b1;
            bus.wdata = ~lo_before;
        end
        @(posedge clk); #1;
        bus.start = 1'b0;
        bus.lo_we = 1'b0;
        bus.a     = $urandom;
        bus.b     = $urandom;
        chk({tag, "_busy_rise"}, 64'(bus.busy), 64'(1));
        if (poke_kind == 3) chk({tag, "_lo_we_dropped"}, 64'(bus.lo), 64'(lo_before));
        cyc  = 0;
        seen = 1'b0;
        while (!seen && cyc < 100) begin
            if (cyc == poke_at && poke_kind == 1) begin
                bus.hi_we = 1'b1;
                bus.wdata = ~hi_before;
            end
            if (cyc == poke_at && poke_kind == 2) begin
                bus.start = 1'b1;
                bus.op    = 2'($urandom_range(0, 3));
            end
            @(posedge clk); #1;
            cyc++;
            bus.hi_we = 1'b0;
            bus.start = 1'b0;
            if (poke_kind == 1 && cyc == poke_at + 1)
                chk({tag, "_hi_we_ignored"}, 64'(bus.hi), 64'(hi_before));
            seen = bus.done;
        end
        chk({tag, "_latency"}, 64'(cyc), 64'(33));
        chk({tag, "_busy_fall"}, 64'(bus.busy), 64'(0));
        chk({tag, "_hilo"}, {bus.hi, bus.lo}, exp);
        @(posedge clk); #1;
        chk({tag, "_done_pulse"}, 64'(bus.done), 64'(0));
        if (poke_kind == 2) chk({tag, "_no_requeue"}, 64'(bus.busy), 64'(0));
    endtask

    initial begin
        logic [1:0]  rop;
        logic [31:0] ra, rb;
        int          done_cnt;
        n_cmp = 0;
        n_err = 0;
        rst       = 1'b0;
        bus.start = 1'b0;
        bus.op    = 2'b00;
        bus.a     = '0;
        bus.b     = '0;
        bus.hi_we = 1'b0;
        bus.lo_we = 1'b0;
        bus.wdata = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_hilo", {bus.hi, bus.lo}, 64'(0));
        chk("reset_busy_done", {62'(0), bus.busy, bus.done}, 64'(0));
        @(negedge clk);
        rst = 1'b1;

        run_op("multu_max", 2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, -1, 0);
        run_op("mult_neg", 2'b01, 32'hFFFFFFFD, 32'd7, -1, 0);
        run_op("div_neg", 2'b11, 32'hFFFFFFF9, 32'd2, -1, 0);
        run_op("divu_100_7", 2'b10, 32'd100, 32'd7, -1, 0);
        run_op("divu_by0", 2'b10, 32'd5, 32'd0, -1, 0);
        run_op("div_by0_neg", 2'b11, 32'hFFFFFFF7, 32'd0, -1, 0);
        run_op("div_ovf", 2'b11, 32'h80000000, 32'hFFFFFFFF, -1, 0);
        run_op("mult_minmin", 2'b01, 32'h80000000, 32'h80000000, -1, 0);

        @(negedge clk);
        bus.hi_we = 1'b1;
        bus.wdata = 32'h12345678;
        @(posedge clk); #1;
        bus.hi_we = 1'b0;
        chk("mthi", 64'(bus.hi), 64'(32'h12345678));
        @(negedge clk);
        bus.lo_we = 1'b1;
        bus.wdata = 32'h9ABCDEF0;
        @(posedge clk); #1;
        bus.lo_we = 1'b0;
        chk("mtlo", 64'(bus.lo), 64'(32'h9ABCDEF0));

        run_op("hi_we_busy", 2'b10, 32'd1000, 32'd33, 5, 1);
        run_op("lo_we_start", 2'b00, 32'd123, 32'd456, -1, 3);
        run_op("start_busy", 2'b01, 32'hFFFF0000, 32'h00012345, 9, 2);

        for (int i = 0; i < 20; i++) begin
            rop = 2'($urandom_range(0, 3));
            ra  = $urandom;
            rb  = $urandom;
            case ($urandom_range(0, 7))
                0: rb = 32'd0;
                1: rb = 32'($urandom_range(1, 15));
                2: begin ra = 32'h80000000; rb = 32'hFFFFFFFF; end
                default: ;
            endcase
            run_op("rand", rop, ra, rb, -1, 0);
        end

        // Abort mid-CALC with asynchronous reset
        @(negedge clk);
        bus.hi_we = 1'b1;
        bus.wdata = 32'hDEADBEEF;
        @(negedge clk);
        bus.hi_we = 1'b0;
        bus.start = 1'b1;
        bus.op    = 2'b00;
        bus.a     = 32'hCAFEF00D;
        bus.b     = 32'h13572468;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (15) @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        chk("abort_hilo", {bus.hi, bus.lo}, 64'(0));
        chk("abort_busy", 64'(bus.busy), 64'(0));
        @(negedge clk);
        rst = 1'b1;
        done_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (bus.done) done_cnt++;
        end
        chk("abort_no_done", 64'(done_cnt), 64'(0));
        run_op("post_abort", 2'b00, 32'd6, 32'd7, -1, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
